ycbcr_frame_ctrl: RTL
=====================

Name: ycbcr_frame_ctrl

Overview:
Frame-level stream controller that sequences the RGB-to-YCbCr converter. It accepts RGB pixels over a valid/ready input, drives the converter's RGB inputs, and tracks each pixel through the converter's fixed pipeline latency. Results are buffered in a small output FIFO with valid/ready backpressure, tagged with start-of-frame, end-of-line and end-of-frame flags. It sits between the pixel source (camera/DMA reader) and the downstream YCbCr consumer, and runs one frame per start pulse.

Parameters:
WIDTH, 640, active pixels per line (>=1)
HEIGHT, 480, lines per frame (>=1)
CW, 8, bits per colour/luma/chroma component
CONV_LAT, 1, converter latency in clocks (>=1)
DEPTH, 4, output FIFO entries (>= CONV_LAT+3, so that full throughput is possible)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high; also routed to the converter
start  in  1  pulse; begins a frame when the controller is in IDLE
s_valid  in  1  input pixel valid
s_ready  out  1  input pixel accepted when s_valid && s_ready
s_r, s_g, s_b  in  CW each  input pixel components
conv_r, conv_g, conv_b  out  CW each  drive converter RGB inputs
conv_y, conv_cb, conv_cr  in  CW each  converter outputs
m_valid  out  1  output pixel valid
m_ready  in  1  downstream ready
m_y, m_cb, m_cr  out  CW each  output pixel components
m_sof  out  1  output pixel is x=0, y=0
m_eol  out  1  output pixel is x=WIDTH-1
m_eof  out  1  output pixel is the last pixel of the frame
busy  out  1  high whenever the FSM is not in IDLE
done  out  1  one-cycle pulse when a frame has fully drained

Behaviour:
- Reset (synchronous): FSM=IDLE; x/y counters, capture register, latency valid pipe and FIFO pointers/occupancy all 0; conv_r/g/b=0. Outputs: s_ready=0, m_valid=0, m_y/m_cb/m_cr=0, all flags 0, busy=0, done=0. Reset asserted mid-frame discards all in-flight and buffered pixels; m_valid is 0 in the cycle after reset.
- FSM states:
  - IDLE: start -> RUN. start outside IDLE is ignored.
  - RUN: after the accept of pixel x=WIDTH-1, y=HEIGHT-1 -> DRAIN.
  - DRAIN: when the latency pipe is empty, FIFO occupancy is 0 and no push is pending -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Input acceptance: s_ready = (state==RUN) && (occ + inflight) < DEPTH.
  - inflight = number of set bits in the capture valid bit plus the CONV_LAT-stage valid pipe.
  - s_ready depends only on registered state, never on m_ready or s_valid.
- Pipeline:
  - On accept, the capture register loads s_r/g/b. conv_r/g/b are driven from the capture register.
  - The captured valid bit and {sof, eol, eof} tag shift through CONV_LAT stages alongside the converter.
  - When the last stage is valid, {conv_y, conv_cb, conv_cr, tag} are pushed into the FIFO on that edge.
  - The capture register advances every cycle; a stage with no accept shifts in valid=0.
  - Sustained throughput: 1 pixel/clock while m_ready=1.
- Counters: x increments per accept and wraps to 0 at WIDTH-1, at which point y increments; y wraps to 0 after HEIGHT-1.
  - Tags are computed from x/y at accept time.
  - WIDTH=1 sets both sof and eol on each pixel; WIDTH=HEIGHT=1 sets sof, eol and eof on the single pixel.
- FIFO:
  - m_valid = occ>0; m_* present the head entry.
  - Pop on m_valid && m_ready.
  - Simultaneous push and pop leaves occ unchanged.
  - The credit rule guarantees a push never hits a full FIFO.
  - Head data and flags hold stable while m_valid && !m_ready.
- Latency: input accept to m_valid = CONV_LAT+2 clocks when the FIFO is empty.
- Pixels are never dropped, duplicated or reordered. The controller does not modify converter results.

Test Plan:
- WIDTH=4, HEIGHT=2, s_valid=1 and m_ready=1 continuously, all pixels R=G=B=255:
  - 8 outputs, each Y=235, Cb=128, Cr=128.
  - m_sof only on output 0; m_eol on outputs 3 and 7; m_eof only on output 7.
  - done pulses once; busy then drops.
- Same frame with R=G=B=0 and m_ready held 0:
  - s_ready falls after DEPTH pixels are in flight or buffered.
  - m_valid=1 with head Y=16, Cb=128, Cr=128 held stable.
  - Releasing m_ready delivers all 8 in order with no loss.
- Random s_valid and m_ready gaps over a WIDTH=4, HEIGHT=3 frame with an incrementing pixel pattern: output sequence matches a reference model exactly; the FIFO never overflows.
- Reset asserted after 3 accepts:
  - Next cycle m_valid=0, s_ready=0, busy=0.
  - A new start produces m_sof on the first new pixel.
- start pulsed while busy: ignored, with frame count and flags unaffected. start in IDLE with s_valid=0: busy=1, s_ready=1, no outputs.
- WIDTH=1, HEIGHT=1: the single output has m_sof=m_eol=m_eof=1, and done fires CONV_LAT+3 clocks after the accept with m_ready=1.

Source files
------------

// File: rtl/ycbcr_frame_ctrl.sv
// Frame sequencer around an external RGB->YCbCr converter.
// Accepts RGB pixels under a credit rule, tracks each pixel through the
// converter latency, and buffers results with frame/line tags in a small FIFO.
`timescale 1ns/1ps
module ycbcr_frame_ctrl #(
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int CW       = 8,
  parameter int CONV_LAT = 1,
  parameter int DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [CW-1:0] s_r,
  input  logic [CW-1:0] s_g,
  input  logic [CW-1:0] s_b,
  output logic [CW-1:0] conv_r,
  output logic [CW-1:0] conv_g,
  output logic [CW-1:0] conv_b,
  input  logic [CW-1:0] conv_y,
  input  logic [CW-1:0] conv_cb,
  input  logic [CW-1:0] conv_cr,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [CW-1:0] m_y,
  output logic [CW-1:0] m_cb,
  output logic [CW-1:0] m_cr,
  output logic          m_sof,
  output logic          m_eol,
  output logic          m_eof,
  output logic          busy,
  output logic          done
);
  localparam int XW   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int PW   = (DEPTH  > 1) ? $clog2(DEPTH)  : 1;
  localparam int OW   = $clog2(DEPTH + 1);
  localparam int CNTW = $clog2(DEPTH + CONV_LAT + 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef struct packed { logic sof; logic eol; logic eof; } tag_t;
  typedef struct packed { logic [CW-1:0] y; logic [CW-1:0] cb; logic [CW-1:0] cr; tag_t tag; } ent_t;

  state_t          state;
  logic [XW-1:0]   x_cnt;
  logic [YW-1:0]   y_cnt;
  logic [CONV_LAT:0] vld_pipe;   // [0] = capture register, [CONV_LAT] = converter output
  tag_t            tag_pipe [CONV_LAT+1];
  ent_t            fifo_mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [OW-1:0]   occ;
  logic [CNTW-1:0] inflight, credit_used;
  logic            accept, push, pop, last_x, last_y, drain_empty;
  tag_t            in_tag;
  ent_t            head;

  // Credits: everything captured, in the converter, or buffered must fit in the FIFO
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= CONV_LAT; i++) inflight = inflight + CNTW'(vld_pipe[i]);
    credit_used = inflight + CNTW'(occ);
  end

  assign s_ready = (state == RUN) && (credit_used < CNTW'(DEPTH));
  assign accept  = s_valid && s_ready;
  assign push    = vld_pipe[CONV_LAT];
  assign pop     = m_valid && m_ready;
  assign last_x  = (x_cnt == XW'(WIDTH - 1));
  assign last_y  = (y_cnt == YW'(HEIGHT - 1));
  assign in_tag  = '{sof: (x_cnt == '0) && (y_cnt == '0), eol: last_x, eof: last_x && last_y};
  // Drain finishes on the edge where the last buffered pixel leaves
  assign drain_empty = (vld_pipe == '0) && ((occ == '0) || ((occ == OW'(1)) && pop));

  // Frame sequencer with registered busy/done
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:  if (start) begin state <= RUN; busy <= 1'b1; end
        RUN:   if (accept && in_tag.eof) state <= DRAIN;
        DRAIN: if (drain_empty) begin state <= DONE; done <= 1'b1; end
        DONE:  begin state <= IDLE; busy <= 1'b0; end
        default: state <= IDLE;
      endcase
    end
  end

  // Raster position of the next pixel to be accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (state == IDLE && start) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (accept) begin
      if (last_x) begin
        x_cnt <= '0;
        y_cnt <= last_y ? '0 : y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  // Capture register and valid/tag pipe matching the converter latency
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      conv_r   <= '0;
      conv_g   <= '0;
      conv_b   <= '0;
      for (int i = 0; i <= CONV_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[CONV_LAT-1:0], accept};
      tag_pipe[0] <= accept ? in_tag : '0;
      for (int i = 1; i <= CONV_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      if (accept) begin
        conv_r <= s_r;
        conv_g <= s_g;
        conv_b <= s_b;
      end
    end
  end

  // Output FIFO; credits guarantee push never meets a full buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= '{y: conv_y, cb: conv_cb, cr: conv_cr, tag: tag_pipe[CONV_LAT]};
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign head    = fifo_mem[rd_ptr];
  assign m_valid = (occ != '0);
  assign m_y     = head.y;
  assign m_cb    = head.cb;
  assign m_cr    = head.cr;
  assign m_sof   = head.tag.sof;
  assign m_eol   = head.tag.eol;
  assign m_eof   = head.tag.eof;
endmodule
